// File: rtl/cluster_accumulator_pkg.sv
// kmeans_pkg: shared constants, FSM state type and label-width helper for
// the K-means cluster accumulator (cluster_accumulator, cluster_acc_bank,
// cluster_accumulator_if).
package kmeans_pkg;

  localparam int unsigned K     = 4;   // number of clusters
  localparam int unsigned DW    = 8;   // coordinate width (unsigned)
  localparam int unsigned SUM_W = 20;  // per-cluster coordinate sum width
  localparam int unsigned CNT_W = 12;  // per-cluster member count width
  localparam int unsigned QW    = 8;   // divider quotient width

  // Smallest width able to encode n distinct labels (minimum 1 bit).
  function automatic int unsigned label_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

  localparam int unsigned LW = label_width(K);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } acc_state_t;

endpackage

// File: rtl/cluster_accumulator_if.sv
// cluster_accumulator_if: bundles the labelled point stream, the divider
// request/response handshake and the centroid/status outputs.
//   slave  : accumulator side (consumes points, drives divider requests)
//   master : environment side (produces points, answers divider requests)
interface cluster_accumulator_if;
  import kmeans_pkg::*;

  logic                pt_valid;
  logic                pt_ready;
  logic [DW-1:0]       pt_x;
  logic [DW-1:0]       pt_y;
  logic [LW-1:0]       pt_label;
  logic                pt_last;

  logic                div_valid;
  logic [SUM_W-1:0]    div_dividend;
  logic [CNT_W-1:0]    div_divisor;
  logic                div_done;
  logic [QW-1:0]       div_quot;

  logic [K*DW-1:0]     cent_x;
  logic [K*DW-1:0]     cent_y;
  logic                epoch_done;
  logic                overflow;

  modport slave (
    input  pt_valid, pt_x, pt_y, pt_label, pt_last, div_done, div_quot,
    output pt_ready, div_valid, div_dividend, div_divisor,
           cent_x, cent_y, epoch_done, overflow
  );

  modport master (
    output pt_valid, pt_x, pt_y, pt_label, pt_last, div_done, div_quot,
    input  pt_ready, div_valid, div_dividend, div_divisor,
           cent_x, cent_y, epoch_done, overflow
  );

endinterface

// File: rtl/cluster_acc_bank.sv
// cluster_acc_bank: K x (sum_x, sum_y, cnt) register file.
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en         : accumulate (wr_x, wr_y) into cluster wr_label
//   wr_sat        : write attempted on a cluster whose count is saturated
//                   (the point is dropped)
//   clr           : synchronous clear of every sum and count
//   rd_k, rd_d    : combinational read index (rd_d = 0 -> x, 1 -> y)
//   rd_sum, rd_cnt: selected sum and the count of cluster rd_k
module cluster_acc_bank
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [LW-1:0]    wr_label,
  input  logic [DW-1:0]    wr_x,
  input  logic [DW-1:0]    wr_y,
  output logic             wr_sat,
  input  logic             clr,
  input  logic [LW-1:0]    rd_k,
  input  logic             rd_d,
  output logic [SUM_W-1:0] rd_sum,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [SUM_W-1:0] sum_x_q [K];
  logic [SUM_W-1:0] sum_x_d [K];
  logic [SUM_W-1:0] sum_y_q [K];
  logic [SUM_W-1:0] sum_y_d [K];
  logic [CNT_W-1:0] cnt_q   [K];
  logic [CNT_W-1:0] cnt_d   [K];

  logic label_ok;

  // Widen before comparing so a label field that can exceed K-1 is caught
  // when K is not a power of two.
  assign label_ok = (32'(wr_label) < K);
  assign wr_sat   = wr_en && label_ok && (cnt_q[wr_label] == '1);

  always_comb begin
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    if (clr) begin
      for (int unsigned i = 0; i < K; i++) begin
        sum_x_d[i] = '0;
        sum_y_d[i] = '0;
        cnt_d[i]   = '0;
      end
    end else if (wr_en && label_ok && !wr_sat) begin
      sum_x_d[wr_label] = sum_x_q[wr_label] + SUM_W'(wr_x);
      sum_y_d[wr_label] = sum_y_q[wr_label] + SUM_W'(wr_y);
      cnt_d[wr_label]   = cnt_q[wr_label] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_x_q <= '{default: '0};
      sum_y_q <= '{default: '0};
      cnt_q   <= '{default: '0};
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_sum = rd_d ? sum_y_q[rd_k] : sum_x_q[rd_k];
  assign rd_cnt = cnt_q[rd_k];

endmodule

// File: rtl/cluster_accumulator.sv
// cluster_accumulator: K-means update step. Accumulates labelled 2-D points
// into per-cluster sums/counts, then asks an external sequential divider for
// each non-empty (cluster, dimension) mean and captures the quotients as the
// new centroids.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cluster_accumulator_if.slave
//              point stream   pt_valid/pt_ready/pt_x/pt_y/pt_label/pt_last
//              divider        div_valid/div_dividend/div_divisor/div_done/div_quot
//              results        cent_x/cent_y (cluster k at [k*DW +: DW]),
//                             epoch_done pulse, sticky overflow
module cluster_accumulator
  import kmeans_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  cluster_accumulator_if.slave bus
);

  acc_state_t       state_q, state_d;
  logic [LW-1:0]    k_q, k_d;
  logic             d_q, d_d;            // 0 -> x, 1 -> y
  logic             pt_ready_q, pt_ready_d;
  logic             div_valid_q, div_valid_d;
  logic [SUM_W-1:0] dividend_q, dividend_d;
  logic [CNT_W-1:0] divisor_q, divisor_d;
  logic             epoch_done_q, epoch_done_d;
  logic             overflow_q, overflow_d;
  logic [DW-1:0]    cx_q [K];
  logic [DW-1:0]    cx_d [K];
  logic [DW-1:0]    cy_q [K];
  logic [DW-1:0]    cy_d [K];

  logic             accept;
  logic             wr_sat;
  logic             bank_clr;
  logic [SUM_W-1:0] rd_sum;
  logic [CNT_W-1:0] rd_cnt;
  logic             last_k;

  assign accept   = bus.pt_valid && pt_ready_q;
  assign bank_clr = (state_q == S_DONE);
  assign last_k   = (k_q == LW'(K - 1));

  cluster_acc_bank u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_label (bus.pt_label),
    .wr_x     (bus.pt_x),
    .wr_y     (bus.pt_y),
    .wr_sat   (wr_sat),
    .clr      (bank_clr),
    .rd_k     (k_q),
    .rd_d     (d_q),
    .rd_sum   (rd_sum),
    .rd_cnt   (rd_cnt)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    d_d          = d_q;
    div_valid_d  = 1'b0;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    epoch_done_d = 1'b0;
    overflow_d   = overflow_q | (accept && wr_sat);
    cx_d         = cx_q;
    cy_d         = cy_q;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) state_d = bus.pt_last ? S_ISSUE : S_ACCUM;
      end
      S_ISSUE: begin
        if (rd_cnt == '0) begin
          // Empty cluster: both dimensions skipped in this one cycle.
          d_d = 1'b0;
          if (last_k) begin
            k_d          = '0;
            state_d      = S_DONE;
            epoch_done_d = 1'b1;
          end else begin
            k_d = k_q + LW'(1);
          end
        end else begin
          div_valid_d = 1'b1;
          dividend_d  = rd_sum;
          divisor_d   = rd_cnt;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.div_done) begin
          if (d_q) cy_d[k_q] = DW'(bus.div_quot);
          else     cx_d[k_q] = DW'(bus.div_quot);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Hold off until the divider drops done so a long done pulse can
        // neither double-capture nor overlap the next request.
        if (!bus.div_done) begin
          if (!d_q) begin
            d_d     = 1'b1;
            state_d = S_ISSUE;
          end else if (last_k) begin
            d_d          = 1'b0;
            k_d          = '0;
            state_d      = S_DONE;
            epoch_done_d = 1'b1;
          end else begin
            d_d     = 1'b0;
            k_d     = k_q + LW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        overflow_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so pt_ready reads 0 under reset yet
    // still tracks IDLE/ACCUM exactly once running.
    pt_ready_d = (state_d == S_IDLE) || (state_d == S_ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      d_q          <= 1'b0;
      pt_ready_q   <= 1'b0;
      div_valid_q  <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      epoch_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cx_q         <= '{default: '0};
      cy_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      d_q          <= d_d;
      pt_ready_q   <= pt_ready_d;
      div_valid_q  <= div_valid_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      epoch_done_q <= epoch_done_d;
      overflow_q   <= overflow_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  logic [K*DW-1:0] cent_x_flat, cent_y_flat;

  always_comb begin
    cent_x_flat = '0;
    cent_y_flat = '0;
    for (int unsigned i = 0; i < K; i++) begin
      cent_x_flat[i*DW +: DW] = cx_q[i];
      cent_y_flat[i*DW +: DW] = cy_q[i];
    end
  end

  assign bus.pt_ready     = pt_ready_q;
  assign bus.div_valid    = div_valid_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.cent_x       = cent_x_flat;
  assign bus.cent_y       = cent_y_flat;
  assign bus.epoch_done   = epoch_done_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_cluster_accumulator.sv
module tb_cluster_accumulator;
  import kmeans_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cluster_accumulator_if bus ();

  cluster_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned   m_sx [K];
  int unsigned   m_sy [K];
  int unsigned   m_cnt[K];
  logic [DW-1:0] m_cx [K];
  logic [DW-1:0] m_cy [K];
  logic [DW-1:0] n_cx [K];
  logic [DW-1:0] n_cy [K];
  bit            m_busy;
  bit            m_ovf;
  int unsigned   eq_dvd[$];
  int unsigned   eq_dvs[$];
  int unsigned   epochs = 0;
  int unsigned   reqs = 0;
  int unsigned   last_dvd, last_dvs;
  bit            have_req;
  int unsigned   force_hold = 0;

  function automatic logic [K*DW-1:0] pack(input logic [DW-1:0] a[K]);
    logic [K*DW-1:0] r;
    for (int i = 0; i < K; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < K; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
      m_cx[i] = '0; m_cy[i] = '0; n_cx[i] = '0; n_cy[i] = '0;
    end
    m_busy = 0; m_ovf = 0; have_req = 0;
    eq_dvd.delete(); eq_dvs.delete();
  endtask

  // Compare process: checks outputs against the model every cycle, then
  // folds this cycle's accepted point into the model.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      chk("pt_ready", bus.pt_ready, !m_busy);
      chk("overflow", bus.overflow, m_ovf);
      if (!m_busy) begin
        chk("cent_x_idle", bus.cent_x, pack(m_cx));
        chk("cent_y_idle", bus.cent_y, pack(m_cy));
      end
      if (have_req && !bus.div_valid) begin
        chk("dividend_stable", bus.div_dividend, last_dvd);
        chk("divisor_stable", bus.div_divisor, last_dvs);
      end
      if (bus.div_valid) begin
        reqs++;
        chk("done_low_at_request", bus.div_done, 0);
        if (eq_dvd.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_request: got %0d/%0d expected none",
                   bus.div_dividend, bus.div_divisor);
        end else begin
          chk("req_dividend", bus.div_dividend, eq_dvd.pop_front());
          chk("req_divisor", bus.div_divisor, eq_dvs.pop_front());
        end
        last_dvd = bus.div_dividend;
        last_dvs = bus.div_divisor;
        have_req = 1;
      end
      if (bus.epoch_done) begin
        epochs++;
        chk("epoch_expected", m_busy, 1);
        chk("pending_requests", eq_dvd.size(), 0);
        m_cx = n_cx;
        m_cy = n_cy;
        chk("cent_x_epoch", bus.cent_x, pack(m_cx));
        chk("cent_y_epoch", bus.cent_y, pack(m_cy));
        m_busy = 0;
        m_ovf  = 0;
      end
      if (bus.pt_valid && bus.pt_ready) begin
        int unsigned l;
        l = 32'(bus.pt_label);
        if (l < K) begin
          if (m_cnt[l] == (1 << CNT_W) - 1) m_ovf = 1;
          else begin
            m_sx[l] += bus.pt_x;
            m_sy[l] += bus.pt_y;
            m_cnt[l] += 1;
          end
        end
        if (bus.pt_last) begin
          for (int k = 0; k < K; k++) begin
            n_cx[k] = m_cx[k];
            n_cy[k] = m_cy[k];
            if (m_cnt[k] != 0) begin
              eq_dvd.push_back(m_sx[k]); eq_dvs.push_back(m_cnt[k]);
              eq_dvd.push_back(m_sy[k]); eq_dvs.push_back(m_cnt[k]);
              n_cx[k] = DW'(m_sx[k] / m_cnt[k]);
              n_cy[k] = DW'(m_sy[k] / m_cnt[k]);
            end
            m_sx[k] = 0; m_sy[k] = 0; m_cnt[k] = 0;
          end
          m_busy = 1;
        end
      end
    end
  end

  // ---------------- divider model ----------------
  initial begin
    int unsigned phase, lat, hold, dvd, dvs;
    phase = 0; lat = 0; hold = 0; dvd = 0; dvs = 1;
    bus.div_done = 1'b0;
    bus.div_quot = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        phase = 0;
        bus.div_done = 1'b0;
        bus.div_quot = '0;
      end else begin
        case (phase)
          0: begin
            if (bus.div_valid) begin
              dvd = bus.div_dividend;
              dvs = bus.div_divisor;
              lat = $urandom_range(0, 3);
              phase = 1;
            end else if (!m_busy && $urandom_range(0, 9) == 0) begin
              bus.div_done = 1'b1;           // stray done, must be ignored
              bus.div_quot = QW'($urandom);
              phase = 3;
            end
          end
          1: begin
            if (lat == 0) begin
              bus.div_done = 1'b1;
              bus.div_quot = QW'(dvd / dvs);
              hold = (force_hold != 0) ? force_hold - 1 : $urandom_range(0, 2);
              phase = 2;
            end else lat--;
          end
          2: begin
            if (hold == 0) begin
              bus.div_done = 1'b0;
              phase = 0;
            end else begin
              hold--;
              bus.div_quot = QW'($urandom); // only the first done cycle counts
            end
          end
          default: begin
            bus.div_done = 1'b0;
            phase = 0;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the point is taken.
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [LW-1:0] l, input logic last);
    int n;
    bus.pt_valid = 1'b1; bus.pt_x = x; bus.pt_y = y;
    bus.pt_label = l; bus.pt_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.pt_ready) break;
      n++;
      if (n > 5000) begin
        tests++; fails++;
        $display("FAIL send_timeout: got ready=0 expected ready=1");
        break;
      end
    end
    sync();
    bus.pt_valid = 1'b0; bus.pt_last = 1'b0;
  endtask

  task automatic wait_epoch(input int unsigned target);
    int n;
    n = 0;
    while (epochs < target && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("epoch_reached", epochs >= target, 1);
    sync();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pt_ready"}, bus.pt_ready, 0);
    chk({tag, "_div_valid"}, bus.div_valid, 0);
    chk({tag, "_div_dividend"}, bus.div_dividend, 0);
    chk({tag, "_div_divisor"}, bus.div_divisor, 0);
    chk({tag, "_cent_x"}, bus.cent_x, 0);
    chk({tag, "_cent_y"}, bus.cent_y, 0);
    chk({tag, "_epoch_done"}, bus.epoch_done, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
  endtask

  task automatic release_rst();
    @(negedge clk); #1;
    rst = 1'b0;
    sync();
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic send_test1();
    send(8'd10, 8'd20, LW'(0), 1'b0);
    send(8'd30, 8'd40, LW'(0), 1'b0);
    send(8'd100, 8'd0, LW'(1), 1'b0);
    send(8'd50, 8'd50, LW'(1), 1'b1);
  endtask

  initial begin
    int unsigned e0, r0, n;
    rst = 1'b1;
    bus.pt_valid = 1'b0; bus.pt_x = '0; bus.pt_y = '0;
    bus.pt_label = '0; bus.pt_last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    release_rst();

    // Two-cluster epoch with hand-computed means.
    e0 = epochs; r0 = reqs;
    send_test1();
    wait_epoch(e0 + 1);
    chk("t1_cent_x", bus.cent_x, 32'h0000_4B14);
    chk("t1_cent_y", bus.cent_y, 32'h0000_191E);
    chk("t1_requests", reqs - r0, 4);
    chk("t1_last_dividend", last_dvd, 50);
    chk("t1_last_divisor", last_dvs, 2);
    chk("t1_epochs", epochs - e0, 1);

    // Give clusters 2/3 centroid (5,5), then an epoch leaving them empty.
    e0 = epochs;
    send(8'd5, 8'd5, LW'(2), 1'b0);
    send(8'd5, 8'd5, LW'(3), 1'b1);
    wait_epoch(e0 + 1);
    r0 = reqs;
    send(8'd10, 8'd10, LW'(0), 1'b0);
    send(8'd20, 8'd20, LW'(1), 1'b1);
    wait_epoch(e0 + 2);
    chk("t2_cent_x", bus.cent_x, 32'h0505_140A);
    chk("t2_cent_y", bus.cent_y, 32'h0505_140A);
    chk("t2_requests", reqs - r0, 4);

    // Divider holding done for 3 cycles with garbage after the first.
    force_hold = 3;
    e0 = epochs; r0 = reqs;
    send(8'd9, 8'd3, LW'(1), 1'b0);
    send(8'd11, 8'd5, LW'(1), 1'b1);
    wait_epoch(e0 + 1);
    chk("t3_cent_x", bus.cent_x, 32'h0505_0A0A);
    chk("t3_cent_y", bus.cent_y, 32'h0505_040A);
    chk("t3_requests", reqs - r0, 2);
    force_hold = 0;

    // Reset during WAIT of the 2nd request aborts the epoch.
    e0 = epochs; r0 = reqs;
    send_test1();
    n = 0;
    while (reqs < r0 + 2 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t4_second_request_seen", reqs - r0, 2);
    rst = 1'b1;
    #1;
    check_zero("mid_wait_reset");
    repeat (2) @(negedge clk);
    release_rst();
    repeat (20) sync();
    chk("t4_no_epoch_done", epochs - e0, 0);
    send_test1();
    wait_epoch(e0 + 1);
    chk("t4_cent_x", bus.cent_x, 32'h0000_4B14);
    chk("t4_cent_y", bus.cent_y, 32'h0000_191E);

    // Single point carrying pt_last straight from IDLE.
    e0 = epochs; r0 = reqs;
    send(8'd7, 8'd9, LW'(2), 1'b1);
    wait_epoch(e0 + 1);
    chk("t5_requests", reqs - r0, 2);
    chk("t5_last_dividend", last_dvd, 9);
    chk("t5_last_divisor", last_dvs, 1);
    chk("t5_cent_x", bus.cent_x, 32'h0007_4B14);
    chk("t5_cent_y", bus.cent_y, 32'h0009_191E);

    // Count saturation: 4096 points to cluster 3, one dropped.
    do_reset();
    e0 = epochs;
    for (int i = 0; i < 4096; i++) send(8'd255, 8'd255, LW'(3), (i == 4095));
    chk("t6_overflow_set", bus.overflow, 1);
    wait_epoch(e0 + 1);
    chk("t6_last_dividend", last_dvd, 1044225);
    chk("t6_last_divisor", last_dvs, 4095);
    chk("t6_cent_x", bus.cent_x, 32'hFF00_0000);
    chk("t6_cent_y", bus.cent_y, 32'hFF00_0000);
    chk("t6_overflow_cleared", bus.overflow, 0);

    // Randomised epochs against the model.
    for (int e = 0; e < 20; e++) begin
      int unsigned len;
      len = $urandom_range(1, 40);
      e0 = epochs;
      for (int unsigned i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) sync();
        send(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
             LW'($urandom_range(0, K - 1)), (i == len - 1));
      end
      wait_epoch(e0 + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_accumulator.md
# cluster_accumulator

Per-cluster sum/count accumulator for the K-means update step. Consumes a stream of labelled 2-D points, builds a coordinate sum and a member count for each cluster, then drives the downstream sequential divider once per non-empty (cluster, dimension) pair. It captures each quotient as the new centroid coordinate and signals when the full centroid set is updated.

## Interface
- `K`, 4, number of clusters; label width is clog2(K).
- `DW`, 8, coordinate width (unsigned).
- `SUM_W`, 20, per-cluster coordinate sum width.
- `CNT_W`, 12, per-cluster member count width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pt_valid`  in  1  point present this cycle.
- `pt_ready`  out  1  point accepted when `pt_valid && pt_ready`.
- `pt_x`, `pt_y`  in  DW  point coordinates.
- `pt_label`  in  clog2(K)  cluster the point is assigned to.
- `pt_last`  in  1  marks the final point of the epoch.
- `div_valid`  out  1  one-cycle request pulse to the divider.
- `div_dividend`  out  SUM_W  selected sum; held stable from the pulse until `div_done`.
- `div_divisor`  out  CNT_W  selected count; held with the dividend.
- `div_done`  in  1  divider result valid; may stay high for more than 1 cycle.
- `div_quot`  in  8  quotient, which becomes the centroid coordinate.
- `cent_x`, `cent_y`  out  K*DW  flattened centroids; cluster k occupies bits [k*DW +: DW].
- `epoch_done`  out  1  one-cycle pulse; centroids updated.
- `overflow`  out  1  sticky flag: at least one point was dropped on count saturation. Cleared on reset or on the `epoch_done` cycle.

## Operation
- States: IDLE, ACCUM, ISSUE, WAIT, GAP, DONE.
- `pt_ready` = 1 in IDLE and ACCUM only.
- IDLE: an accepted point is accumulated and the FSM moves to ACCUM. If that point also has `pt_last`, the FSM goes to ISSUE instead.
- ACCUM, accepted point with label L: `sum_x[L] += pt_x`, `sum_y[L] += pt_y`, `cnt[L] += 1`.
  - Accepted point with `pt_last`: accumulate, then go to ISSUE.
- Count saturation: if `cnt[L]` is already 2^CNT_W-1, the point is dropped. Sums and count are unchanged and `overflow` is set. Sums cannot then exceed (2^DW-1)*(2^CNT_W-1), which fits in SUM_W.
- Labels >= K are dropped the same way, except `overflow` is not set.
- ISSUE: walks the index (k, d) from k=0, d=x; order is x before y, then k+1.
  - `cnt[k]==0`: no request. The centroid is held and the index advances; both dimensions of cluster k are skipped in one cycle.
  - Otherwise: pulse `div_valid`, drive `sum_d[k]` and `cnt[k]`, go to WAIT.
- WAIT: on the first cycle with `div_done`=1, `cent_d[k] <= div_quot` and the FSM goes to GAP.
- GAP: wait for `div_done`=0, then advance the index.
  - Go to DONE if the index wrapped past (K-1, y); otherwise go to ISSUE.
  - The next request is never issued while `div_done` is still high.
- DONE: pulse `epoch_done`, clear all sums and counts, return to IDLE.
- Division is integer floor; the divider guarantees the quotient fits in 8 bits because mean <= 2^DW-1.

## Timing
- Reset values: all outputs 0, centroids 0, FSM in IDLE, sums and counts 0, `overflow` 0.
- Reset is asynchronous at any point, including mid-ISSUE/WAIT; it aborts the epoch with no `epoch_done`.
- Accumulation throughput: 1 point/cycle, with no bubble between consecutive points.
- Latency from the `pt_last` acceptance cycle:
  - ISSUE is entered on the next cycle.
  - Each non-empty pair costs 1 (ISSUE) + divider latency + GAP cycles.
  - Each empty cluster costs 1 cycle.
- `epoch_done` is asserted 1 cycle after the last GAP exit. `pt_ready` returns to 1 on the following cycle.
- `div_dividend`/`div_divisor` are registered, change only on the ISSUE cycle, and are stable through WAIT and GAP.
- A `div_done` that arrives outside WAIT is ignored.

## Structure
- Shared package `kmeans_pkg`:
  - constants `K`, `DW`, `SUM_W`, `CNT_W`;
  - state enum `acc_state_t`;
  - label width function.
- One natural sub-module: `cluster_acc_bank`. It holds the K×(sum_x, sum_y, cnt) register file, performs the saturating update on the write port, offers a combinational read port indexed by (k, d), and provides a synchronous clear.
- FSM, index counter and centroid capture stay in the top.

## Test plan
- 4 points (10,20,L0), (30,40,L0), (100,0,L1), (50,50,L1) with `pt_last` on the 4th -> requests (40,2), (60,2), (150,2), (50,2). With a model divider, `cent_x`: k0=20, k1=75; `cent_y`: k0=30, k1=25. Clusters 2 and 3 hold 0; `epoch_done` once.
- Clusters 2 and 3 empty after prior centroids (5,5) -> no request issued for k2/k3; centroids remain 5.
- 4096 points of (255,255) to L3 -> count 4095, sum 1044225, `overflow`=1, 1 point dropped. Quotient 255.
- Divider holding `div_done` high 3 cycles -> exactly 1 capture per request; next `div_valid` only after `div_done` low.
- Assert `rst` during WAIT of the 2nd request -> all outputs 0 immediately, no `epoch_done`. A new epoch after release is correct.
- Single point with `pt_last` in IDLE, (7,9,L2) -> requests (7,1), (9,1); `cent` k2 = (7,9).
